// File: rtl/hack_uart_loader.sv
// UART program loader: 8N1 receiver feeding a big-endian word assembler
// that streams a counted image into the program RAM write port.
module hack_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_WIDTH   = 15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  rx,
  output logic [15:0]           ram_in,
  output logic                  ram_load,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_st_e;

  typedef enum logic [2:0] {
    LD_CNT_HI, LD_CNT_LO, LD_DAT_HI,
    LD_DAT_LO, LD_WRITE, LD_FIN
  } ld_st_e;

  logic rx_meta_q, rx_s_q;

  rx_st_e      rx_st_q, rx_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        brk_q, brk_d;
  logic        fe_q, fe_d;
  logic        byte_valid, fe_pulse;

  ld_st_e      ld_st_q, ld_st_d;
  logic [7:0]  cnt_hi_q, cnt_hi_d;
  logic [7:0]  word_hi_q, word_hi_d;
  logic [15:0] rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_in_q, ram_in_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_st_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      brk_q      <= 1'b0;
      fe_q       <= 1'b0;
      ld_st_q    <= LD_CNT_HI;
      cnt_hi_q   <= '0;
      word_hi_q  <= '0;
      rem_q      <= '0;
      addr_q     <= '0;
      ram_addr_q <= '0;
      ram_in_q   <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_st_q    <= rx_st_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      brk_q      <= brk_d;
      fe_q       <= fe_d;
      ld_st_q    <= ld_st_d;
      cnt_hi_q   <= cnt_hi_d;
      word_hi_q  <= word_hi_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      ram_addr_q <= ram_addr_d;
      ram_in_q   <= ram_in_d;
    end
  end

  always_comb begin
    rx_st_d    = rx_st_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    brk_d      = brk_q;
    fe_d       = fe_q;
    byte_valid = 1'b0;
    fe_pulse   = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          rx_st_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          rx_st_d = rx_s_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_st_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        // brk_q: bad stop bit seen, hold until the line idles high
        if (brk_q) begin
          if (rx_s_q) begin
            brk_d   = 1'b0;
            rx_st_d = RX_IDLE;
          end
        end else if (cnt_q == BIT_LAST) begin
          if (rx_s_q) begin
            byte_valid = 1'b1;
            rx_st_d    = RX_IDLE;
          end else begin
            fe_pulse = 1'b1;
            fe_d     = 1'b1;
            brk_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_comb begin
    ld_st_d    = ld_st_q;
    cnt_hi_d   = cnt_hi_q;
    word_hi_d  = word_hi_q;
    rem_d      = rem_q;
    addr_d     = addr_q;
    ram_addr_d = ram_addr_q;
    ram_in_d   = ram_in_q;
    ram_load   = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    unique case (ld_st_q)
      LD_CNT_HI: begin
        if (byte_valid) begin
          cnt_hi_d = shift_q;
          ld_st_d  = LD_CNT_LO;
        end
      end
      LD_CNT_LO: begin
        busy = 1'b1;
        if (byte_valid) begin
          if ({cnt_hi_q, shift_q} == 16'd0) begin
            ld_st_d = LD_FIN;
          end else begin
            rem_d   = {cnt_hi_q, shift_q};
            addr_d  = '0;
            ld_st_d = LD_DAT_HI;
          end
        end
      end
      LD_DAT_HI: begin
        busy = 1'b1;
        if (byte_valid) begin
          word_hi_d = shift_q;
          ld_st_d   = LD_DAT_LO;
        end
      end
      LD_DAT_LO: begin
        busy = 1'b1;
        if (byte_valid) begin
          ram_in_d   = {word_hi_q, shift_q};
          ram_addr_d = addr_q;
          ld_st_d    = LD_WRITE;
        end
      end
      LD_WRITE: begin
        busy     = 1'b1;
        ram_load = 1'b1;
        addr_d   = addr_q + ADDR_WIDTH'(1);
        rem_d    = rem_q - 16'd1;
        ld_st_d  = (rem_q == 16'd1) ? LD_FIN : LD_DAT_HI;
      end
      LD_FIN: begin
        done    = 1'b1;
        ld_st_d = LD_CNT_HI;
      end
      default: ld_st_d = LD_CNT_HI;
    endcase
    if (fe_pulse) ld_st_d = LD_CNT_HI;
  end

  assign ram_in      = ram_in_q;
  assign ram_address = ram_addr_q;
  assign frame_err   = fe_q;

endmodule

// File: doc/hack_uart_loader.md
# hack_uart_loader

Serial program loader sitting directly upstream of the 32K-word data/program RAM. It receives a program image over an 8N1 UART line and assembles big-endian 16-bit words. It drives the RAM's write port (data word, load strobe, 15-bit address) one word at a time. While an image is loading it holds the CPU off through `busy`, and it pulses `done` when the image is complete.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4
- `ADDR_WIDTH`, 15, RAM address width; must match the RAM depth
- `clock`  in  1  single system clock; all logic on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `rx`  in  1  UART receive line, idle high, asynchronous to `clock`
- `ram_in`  out  16  write data to the RAM `in` port
- `ram_load`  out  1  one-cycle write strobe to the RAM `load` port
- `ram_address`  out  ADDR_WIDTH  write address to the RAM `address` port
- `busy`  out  1  high while an image is being received; the CPU is held while high
- `done`  out  1  one-cycle pulse when the last word of an image has been written
- `frame_err`  out  1  sticky; set on any stop-bit error, cleared only by reset

## Operation
- `rx` passes through a 2-flop synchronizer. All receive logic uses the synchronized value.
- **UART RX FSM (IDLE, START, DATA, STOP):**
  - IDLE: waits for the synchronized `rx` to go low.
  - START: waits CLKS_PER_BIT/2 cycles (integer divide), then re-samples. If `rx` is high it is a false start: no byte, return to IDLE.
  - DATA: samples 8 bits, LSB first, one every CLKS_PER_BIT cycles.
  - STOP: samples once after CLKS_PER_BIT cycles. If high, the byte is valid: an internal one-cycle `byte_valid` pulse, then IDLE. If low, `frame_err` is set, the byte is discarded, the loader aborts, and the FSM waits in STOP until `rx` is high before returning to IDLE.
- **Loader FSM (CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, FIN):**
  - CNT_HI: on a byte, store it as count[15:8], set `busy`=1, go to CNT_LO.
  - CNT_LO: on a byte, store it as count[7:0]. If count==0, go to FIN. Otherwise clear the address to 0 and go to DAT_HI.
  - DAT_HI: on a byte, store it as word[15:8].
  - DAT_LO: on a byte, store it as word[7:0], go to WRITE.
  - WRITE: for one cycle, `ram_load`=1 with `ram_in`=word and `ram_address`=the current address. Next cycle: address+1 (modulo 2^ADDR_WIDTH) and remaining-1. If remaining reaches 0 go to FIN, else go to DAT_HI.
  - FIN: for one cycle, `done`=1 and `busy`=0, then go to CNT_HI, ready for the next image.
- Counts above 2^ADDR_WIDTH wrap the address; later words overwrite earlier ones. No error is flagged.
- Frame-error abort: the loader returns to CNT_HI, `busy`=0, no `done`, no further writes. Words already written remain in the RAM.
- `ram_in` and `ram_address` hold their last values between writes. The RAM's registered read path is unaffected because `ram_load` is 0 outside WRITE.

## Timing
- **Reset values:** `ram_in`=0, `ram_load`=0, `ram_address`=0, `busy`=0, `done`=0, `frame_err`=0. The RX FSM resets to IDLE and the loader to CNT_HI. Reset asserted mid-image aborts immediately with no partial write strobe.
- **Byte latency:** `byte_valid` fires about 9.5×CLKS_PER_BIT + 2 synchronizer cycles after the start-bit falling edge.
- **Write latency:** `ram_load` is high in the cycle after the `byte_valid` that completes the low byte. `ram_in`/`ram_address` are valid in that same cycle, so the RAM captures them on the next rising edge.
- **Done latency:** `done` pulses the cycle after the final WRITE cycle. For count==0 it pulses the cycle after the count low byte.
- Exactly one `ram_load` cycle per word; `ram_load` and `done` are never high together.
- `busy` rises in the cycle after the count-high byte and falls in the FIN cycle.
- Back-to-back bytes with no idle gap must be received without loss. WRITE/FIN take one cycle each, far shorter than one bit time.

## Test plan
- **Basic load:** CLKS_PER_BIT=4; send 00 02 12 34 AB CD. Expect two `ram_load` pulses: (addr 0, 0x1234) then (addr 1, 0xABCD). Expect one `done`; `busy` 0 afterwards.
- **Zero count:** send 00 00. Expect `done` one cycle after the second byte and no `ram_load`.
- **Frame error:** send 00 03 11 22, then a byte with the stop bit low. Expect `frame_err`=1 and one write (addr 0, 0x1122). Expect `busy`=0 and no `done`. A following 00 01 55 AA writes 0x55AA at addr 0.
- **False start:** a 1-cycle low glitch on `rx` produces no byte and no state change. A subsequent valid image loads normally.
- **Reset mid-image:** assert `reset_n`=0 after byte 3 of 00 02 12 34 AB CD. All outputs are 0 immediately. After release, a fresh 00 01 BE EF writes 0xBEEF at addr 0.
- **Address wrap:** set ADDR_WIDTH=2 and send a count of 5 with words 1..5. Expect addresses 0,1,2,3,0, with word 5 at addr 0, and `done` after the fifth write.
